// File: rtl/snd_cmd_irq_ctrl_if.sv
// Bus between the main/sound CPU glue and the sound command/interrupt controller.
// The master side drives strobes, data and FM IRQ lines. The slave side is the controller.
interface snd_cmd_irq_ctrl_if #(
    parameter int unsigned NIRQ = 2
);
    logic            mcode_wr;
    logic [7:0]      mcode_din;
    logic            cmd_rd;
    logic [7:0]      cmd_dout;
    logic            stat_rd;
    logic [7:0]      stat_dout;
    logic            stat_wr;
    logic [7:0]      stat_din;
    logic [NIRQ-1:0] irq_src_n;
    logic            int_n;
    logic            ms;
    logic            fifo_full;

    modport master (
        output mcode_wr, mcode_din, cmd_rd, stat_rd, stat_wr, stat_din, irq_src_n,
        input  cmd_dout, stat_dout, int_n, ms, fifo_full
    );

    modport slave (
        input  mcode_wr, mcode_din, cmd_rd, stat_rd, stat_wr, stat_din, irq_src_n,
        output cmd_dout, stat_dout, int_n, ms, fifo_full
    );
endinterface

// File: rtl/snd_cmd_irq_ctrl.sv
// Sound-CPU command FIFO and interrupt controller.
// The main CPU pushes command bytes. The sound CPU pops them and reads a status byte
// {0, OVF, IRQ[NIRQ-1:0] (zero-padded to 4 bits), BUSY, CMD}. It acknowledges flags by
// writing 0 to the matching bits. INT_n is asserted while CMD, BUSY or any IRQ is set.
module snd_cmd_irq_ctrl #(
    parameter int unsigned NIRQ       = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               RESETn,
    snd_cmd_irq_ctrl_if.slave  bus
);
    localparam int unsigned IW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            cmd_q, cmd_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [NIRQ-1:0] irq_q, irq_d, irq_prev_q;
    logic [7:0]      cmd_dout_q, stat_dout_q, status, ack_clr;
    logic            int_n_q;
    logic            empty, full, do_pop, do_push, ovf_set, last_pop;

    // FIFO control, flag next-state and status byte assembly
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
        do_pop   = bus.cmd_rd && !empty;
        // When full, a same-cycle pop frees the slot first, so the push still lands
        do_push  = bus.mcode_wr && (!full || do_pop);
        ovf_set  = bus.mcode_wr && full && !do_pop;
        last_pop = do_pop && !do_push && ((rd_ptr_q + PW'(1)) == wr_ptr_q);
        ack_clr  = bus.stat_wr ? ~bus.stat_din : 8'h00;

        // Set terms are ORed in last so a same-cycle set beats an acknowledge
        cmd_d    = do_push | (cmd_q & ~ack_clr[0] & ~last_pop);
        busy_d   = do_push | (busy_q & ~ack_clr[1]);
        ovf_d    = ovf_set | (ovf_q & ~ack_clr[6]);
        irq_d    = (irq_prev_q & ~bus.irq_src_n) | (irq_q & ~ack_clr[2 +: NIRQ]);

        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        status            = 8'h00;
        status[0]         = cmd_q;
        status[1]         = busy_q;
        status[2 +: NIRQ] = irq_q;
        status[6]         = ovf_q;
    end

    // Command storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[IW-1:0]] <= bus.mcode_din;
        end
    end

    // Pointers, flags, edge detector and registered outputs
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_q       <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= '0;
            irq_prev_q  <= '1;
            cmd_dout_q  <= 8'hFF;
            stat_dout_q <= 8'h00;
            int_n_q     <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cmd_q      <= cmd_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            irq_prev_q <= bus.irq_src_n;
            if (bus.cmd_rd) begin
                cmd_dout_q <= do_pop ? mem[rd_ptr_q[IW-1:0]] : 8'hFF;
            end
            if (bus.stat_rd) begin
                stat_dout_q <= status;
            end
            // Built from registered flags, so INT_n lags a flag change by one clock
            int_n_q <= ~(cmd_q | busy_q | (|irq_q));
        end
    end

    assign bus.cmd_dout  = cmd_dout_q;
    assign bus.stat_dout = stat_dout_q;
    assign bus.int_n     = int_n_q;
    assign bus.ms        = busy_q;
    assign bus.fifo_full = full;

endmodule
